// File: rtl/jt12_reg_wr.sv
// jt12_reg_wr: CPU write-port front end decoding YM2612 channel registers 0xA0-0xB6.
// Latency: update strobes fire on the accepting clock when cen=1, else on the next cen=1 clock.
// Backpressure: none; writes are always accepted, busy is advisory status for the CPU.
//
// Ports:
//   i_rst, i_clk, i_cen        async active-high reset, clock, clock enable
//   i_cs_n, i_wr_n             active-low chip select / write strobe
//   i_addr[1:0]                [0]=0 address, [0]=1 data; [1]=part (channels 3-5)
//   i_din[7:0]                 CPU data bus
//   o_dout[7:0]                status byte {busy,7'd0}
//   o_wr_data[7:0]             data byte held for the channel register stage
//   o_up_ch[2:0]               target channel {part,sel[1:0]}
//   o_latch_fnum[5:0]          {block,fnum[10:8]} for the channel in o_up_ch
//   o_up_fnumlo/alg/pms        one-clock update strobes
//   o_busy                     write-busy flag
//
// Build option: JT12_SHARED_FNUM_LATCH_EN selects one F-num high latch shared by all
// channels (chip behaviour); without it each channel keeps its own latch.
module jt12_reg_wr #(
    parameter int NUM_CH   = 6,
    parameter int BUSY_CYC = 32
) (
    input  logic       i_rst,
    input  logic       i_clk,
    input  logic       i_cen,
    input  logic       i_cs_n,
    input  logic       i_wr_n,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic [7:0] o_wr_data,
    output logic [2:0] o_up_ch,
    output logic [5:0] o_latch_fnum,
    output logic       o_up_fnumlo,
    output logic       o_up_alg,
    output logic       o_up_pms,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        UP_NONE   = 2'd0,
        UP_FNUMLO = 2'd1,
        UP_ALG    = 2'd2,
        UP_PMS    = 2'd3
    } up_kind_t;

    localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYC);

    logic       r_we;
    logic [7:0] r_sel;
    logic       r_part;
    up_kind_t   r_pend;
    logic [7:0] r_wr_data;
    logic [2:0] r_up_ch;
    logic [5:0] r_latch_fnum;
    logic       r_up_fnumlo;
    logic       r_up_alg;
    logic       r_up_pms;
    logic [7:0] r_busy_cnt;
    logic       r_busy;

    logic       w_we;
    logic       w_acc;
    logic       w_addr_wr;
    logic       w_data_wr;
    logic       w_ch_ok;
    logic       w_is_fhi;
    up_kind_t   w_kind;
    up_kind_t   w_fire;
    logic [2:0] w_ch;
    logic [5:0] w_fnum_rd;

    // Only the rising edge of the combined write enable counts, so a long
    // wr_n pulse is a single access.
    assign w_we      = ~i_cs_n & ~i_wr_n;
    assign w_acc     = w_we & ~r_we;
    assign w_addr_wr = w_acc & ~i_addr[0];
    assign w_data_wr = w_acc &  i_addr[0];

    // sel[1:0]==3 has no channel behind it in any register group.
    assign w_ch_ok  = (r_sel[1:0] != 2'd3);
    assign w_is_fhi = w_ch_ok && (r_sel[7:2] == 6'b1010_01);
    assign w_ch     = {r_part, r_sel[1:0]};

    always_comb begin
        w_kind = UP_NONE;
        if (w_ch_ok) begin
            case (r_sel[7:2])
                6'b1010_00: w_kind = UP_FNUMLO;
                6'b1011_00: w_kind = UP_ALG;
                6'b1011_01: w_kind = UP_PMS;
                default:    w_kind = UP_NONE;
            endcase
        end
    end

    // A write landing on a cen clock fires straight away and supersedes
    // anything still pending; otherwise the pending strobe waits for cen.
    always_comb begin
        w_fire = UP_NONE;
        if (i_cen) begin
            w_fire = w_data_wr ? w_kind : r_pend;
        end
    end

`ifdef JT12_SHARED_FNUM_LATCH_EN
    logic [5:0] r_fnum_hi;

    assign w_fnum_rd = r_fnum_hi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fnum_hi <= '0;
        end else if (w_data_wr && w_is_fhi) begin
            r_fnum_hi <= i_din[5:0];
        end
    end
`else
    localparam int IW = (NUM_CH == 3) ? 2 : 3;

    logic [5:0]    r_fnum_hi [NUM_CH];
    logic [IW-1:0] w_idx;

    // Channel {part,sel} 0-2 / 4-6 maps onto latch slots 0-5.
    assign w_idx     = IW'({1'b0, r_sel[1:0]} + (r_part ? 3'd3 : 3'd0));
    assign w_fnum_rd = r_fnum_hi[w_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_fnum_hi[i] <= '0;
            end
        end else if (w_data_wr && w_is_fhi) begin
            r_fnum_hi[w_idx] <= i_din[5:0];
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_part       <= 1'b0;
            r_pend       <= UP_NONE;
            r_wr_data    <= '0;
            r_up_ch      <= '0;
            r_latch_fnum <= '0;
            r_up_fnumlo  <= 1'b0;
            r_up_alg     <= 1'b0;
            r_up_pms     <= 1'b0;
            r_busy_cnt   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_we <= w_we;

            if (w_addr_wr) begin
                r_sel  <= i_din;
                r_part <= (NUM_CH == 3) ? 1'b0 : i_addr[1];
            end

            r_up_fnumlo <= (w_fire == UP_FNUMLO);
            r_up_alg    <= (w_fire == UP_ALG);
            r_up_pms    <= (w_fire == UP_PMS);

            if (w_data_wr) begin
                r_wr_data <= i_din;
                r_pend    <= i_cen ? UP_NONE : w_kind;
                // Channel and F-num high are captured at acceptance so later
                // address writes cannot retarget a pending strobe.
                if (w_is_fhi) begin
                    r_up_ch      <= w_ch;
                    r_latch_fnum <= i_din[5:0];
                end else if (w_kind != UP_NONE) begin
                    r_up_ch      <= w_ch;
                    r_latch_fnum <= w_fnum_rd;
                end
            end else if (i_cen) begin
                r_pend <= UP_NONE;
            end

            if (w_data_wr) begin
                r_busy_cnt <= BUSY_LOAD;
                r_busy     <= 1'b1;
            end else if (i_cen && (r_busy_cnt != 8'd0)) begin
                r_busy_cnt <= r_busy_cnt - 8'd1;
                r_busy     <= (r_busy_cnt != 8'd1);
            end
        end
    end

    assign o_dout       = {r_busy, 7'd0};
    assign o_wr_data    = r_wr_data;
    assign o_up_ch      = r_up_ch;
    assign o_latch_fnum = r_latch_fnum;
    assign o_up_fnumlo  = r_up_fnumlo;
    assign o_up_alg     = r_up_alg;
    assign o_up_pms     = r_up_pms;
    assign o_busy       = r_busy;

endmodule
